// File: rtl/ntt_stream_engine.sv
// Streaming N-point NTT/INTT engine: loads a frame in bit-reversed order, runs one
// radix-2 Cooley-Tukey butterfly per cycle in place, then drains results in natural order.
module ntt_stream_engine #(
    parameter int W         = 32,
    parameter int N         = 8,
    parameter int Q         = 17,
    parameter int OMEGA     = 2,
    parameter int OMEGA_INV = 9,
    parameter int N_INV     = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int LOGN = $clog2(N);
    localparam int SW   = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam logic [W-1:0]    Q_W      = W'(Q);
    localparam logic [2*W-1:0]  Q_2W     = (2*W)'(Q);
    localparam logic [W-1:0]    N_INV_W  = W'(N_INV);
    localparam logic [LOGN-1:0] IDX_LAST = LOGN'(N - 1);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % Q_2W);
    endfunction

    function automatic logic [W-1:0] root_pow(input logic [W-1:0] base, input int squarings);
        logic [W-1:0] r;
        r = base;
        for (int i = 0; i < squarings; i++) r = mulmod(r, r);
        return r;
    endfunction

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
        return r;
    endfunction

    // Stage s uses a primitive 2^(s+1)-th root: OMEGA squared (LOGN-1-s) times.
    logic [W-1:0] root_fwd [LOGN];
    logic [W-1:0] root_inv [LOGN];
    for (genvar g = 0; g < LOGN; g++) begin : g_root
        assign root_fwd[g] = root_pow(W'(OMEGA), LOGN - 1 - g);
        assign root_inv[g] = root_pow(W'(OMEGA_INV), LOGN - 1 - g);
    end

    state_t          state_q, state_d;
    logic [LOGN-1:0] idx_q, idx_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [LOGN-1:0] k_q, k_d;
    logic [LOGN-1:0] j_q, j_d;
    logic [W-1:0]    w_q, w_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    a_q [N];
    logic [W-1:0]    a_d [N];
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    out_data_q, out_data_d;

    logic [LOGN-1:0] half, lo, hi;
    logic [LOGN:0]   grp_next;
    logic [W-1:0]    wt, u, t, sum, root_s;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        k_d     = k_q;
        j_d     = j_q;
        w_d     = w_q;
        mode_d  = mode_q;
        a_d     = a_q;

        half     = LOGN'(1) << stage_q;
        lo       = k_q + j_q;
        hi       = lo + half;
        grp_next = {1'b0, k_q} + ({1'b0, half} << 1);
        wt       = (j_q == '0) ? W'(1) : w_q;
        u        = a_q[lo];
        t        = mulmod(wt, a_q[hi]);
        sum      = u + t;
        root_s   = mode_q ? root_inv[stage_q] : root_fwd[stage_q];

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    a_d[bitrev(idx_q)] = in_data % Q_W;
                    if (idx_q == '0) mode_d = inverse;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_COMPUTE;
                        idx_d   = '0;
                        stage_d = '0;
                        k_d     = '0;
                        j_d     = '0;
                        w_d     = W'(1);
                    end else begin
                        idx_d = idx_q + LOGN'(1);
                    end
                end
            end
            S_COMPUTE: begin
                a_d[lo] = (sum >= Q_W) ? sum - Q_W : sum;
                a_d[hi] = (u >= t) ? u - t : u - t + Q_W;
                w_d     = mulmod(wt, root_s);
                if (j_q == half - LOGN'(1)) begin
                    j_d = '0;
                    if (grp_next == (LOGN+1)'(N)) begin
                        k_d = '0;
                        if (stage_q == SW'(LOGN - 1)) begin
                            state_d = S_OUTPUT;
                            idx_d   = '0;
                        end else begin
                            stage_d = stage_q + SW'(1);
                        end
                    end else begin
                        k_d = grp_next[LOGN-1:0];
                    end
                end else begin
                    j_d = j_q + LOGN'(1);
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + LOGN'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        // Outputs are registered from next-state values so they line up with the state they describe.
        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d != S_LOAD);
        out_valid_d = (state_d == S_OUTPUT);
        out_last_d  = out_valid_d && (idx_d == IDX_LAST);
        out_data_d  = '0;
        if (out_valid_d) out_data_d = mode_d ? mulmod(a_d[idx_d], N_INV_W) : a_d[idx_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            stage_q     <= '0;
            k_q         <= '0;
            j_q         <= '0;
            w_q         <= W'(1);
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stage_q     <= stage_d;
            k_q         <= k_d;
            j_q         <= j_d;
            w_q         <= w_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_ntt_stream_engine.sv
// Bench for ntt_stream_engine: directed 8-point vectors plus a 16-point instance
// checked against a direct DFT mod Q with back-to-back frames.
module tb_ntt_stream_engine;

    function automatic int modpow(input int b, input int e, input int m);
        longint r, x;
        r = 1;
        x = longint'(b) % m;
        for (int i = 0; i < e; i++) r = (r * x) % m;
        return int'(r);
    endfunction

    localparam int Q16    = 97;
    localparam int OM16   = 8;
    localparam int OMI16  = modpow(OM16, Q16 - 2, Q16);
    localparam int NINV16 = modpow(16, Q16 - 2, Q16);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid, in_ready, inverse, out_valid, out_ready, out_last, busy;
    logic [31:0] in_data, out_data;
    logic        in_valid_b, in_ready_b, inverse_b, out_valid_b, out_ready_b, out_last_b, busy_b;
    logic [31:0] in_data_b, out_data_b;

    ntt_stream_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inverse(inverse), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    ntt_stream_engine #(.W(32), .N(16), .Q(Q16), .OMEGA(OM16), .OMEGA_INV(OMI16), .N_INV(NINV16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .inverse(inverse_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_last(out_last_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic inv;
        int   din [8];
        int   exp [8];
    } vec_t;
    vec_t vecs [4];

    int   fr16 [4][16];
    logic md16 [4];

    function automatic int dft_ref(input int f, input int k);
        longint acc, om;
        acc = 0;
        om  = md16[f] ? OMI16 : OM16;
        for (int n = 0; n < 16; n++)
            acc = (acc + (longint'(fr16[f][n]) % Q16) * modpow(int'(om), n * k, Q16)) % Q16;
        if (md16[f]) acc = (acc * NINV16) % Q16;
        return int'(acc);
    endfunction

    task automatic load8(input int d[8], input logic inv, input bit gaps);
        int guard;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = d[i];
            inverse  = (i == 0) ? inv : ~inv;
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) check("load_ready", 0, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_fall", in_ready, 0);
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_out8(input bit junk);
        int lat;
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (junk) begin
                in_valid = 1'b1;
                in_data  = $urandom_range(0, 1000);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 12);
    endtask

    task automatic collect8(input int exp[8], input bit toggle);
        int          beat, guard;
        bit          stalled;
        logic [31:0] held_d;
        logic        held_l;
        beat = 0; guard = 0; stalled = 0; held_d = '0; held_l = 1'b0;
        while (beat < 8 && guard < 200) begin
            out_ready = toggle ? guard[0] : 1'b1;
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_d);
                check("stall_last", out_last, held_l);
            end
            if (out_valid && out_ready) begin
                check($sformatf("data[%0d]", beat), out_data, exp[beat]);
                check($sformatf("last[%0d]", beat), out_last, (beat == 7));
                beat++;
                stalled = 0;
            end else if (out_valid) begin
                stalled = 1;
                held_d  = out_data;
                held_l  = out_last;
            end else begin
                stalled = 0;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b1;
        check("beats", beat, 8);
        check("end_ready", in_ready, 1);
        check("end_busy", busy, 0);
        check("end_valid", out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].inv = 1'b0; vecs[0].din = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[0].exp = '{2, 8, 14, 6, 13, 3, 12, 1};
        vecs[1].inv = 1'b1; vecs[1].din = '{2, 8, 14, 6, 13, 3, 12, 1};
        vecs[1].exp = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[2].inv = 1'b0; vecs[2].din = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].exp = '{1, 1, 1, 1, 1, 1, 1, 1};
        vecs[3].inv = 1'b0; vecs[3].din = '{18, 18, 18, 18, 18, 18, 18, 18};
        vecs[3].exp = '{8, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b0;
        in_valid = 0; in_data = 0; inverse = 0; out_ready = 1;
        in_valid_b = 0; in_data_b = 0; inverse_b = 0; out_ready_b = 1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;

        for (int v = 0; v < 4; v++) begin
            load8(vecs[v].din, vecs[v].inv, 1'b0);
            wait_out8(1'b0);
            collect8(vecs[v].exp, 1'b0);
        end

        // Input gaps, junk beats during COMPUTE, and output backpressure.
        load8(vecs[0].din, vecs[0].inv, 1'b1);
        wait_out8(1'b1);
        collect8(vecs[0].exp, 1'b1);

        // Asynchronous reset five butterflies into COMPUTE.
        load8(vecs[0].din, vecs[0].inv, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        load8(vecs[0].din, vecs[0].inv, 1'b0);
        wait_out8(1'b0);
        collect8(vecs[0].exp, 1'b0);

        // 16-point instance, back-to-back frames in both modes.
        for (int f = 0; f < 4; f++) begin
            md16[f] = f[0];
            for (int i = 0; i < 16; i++) fr16[f][i] = int'($urandom_range(0, 300));
        end
        fork
            begin
                int guard;
                for (int f = 0; f < 4; f++) begin
                    for (int i = 0; i < 16; i++) begin
                        @(negedge clk);
                        in_valid_b = 1'b1;
                        in_data_b  = fr16[f][i];
                        inverse_b  = (i == 0) ? md16[f] : ~md16[f];
                        guard = 0;
                        while (!in_ready_b && guard < 2000) begin
                            @(negedge clk);
                            guard++;
                        end
                        if (!in_ready_b) check("n16_load_ready", 0, 1);
                    end
                end
                @(negedge clk);
                in_valid_b = 1'b0;
            end
            begin
                int guard;
                for (int f = 0; f < 4; f++) begin
                    for (int b = 0; b < 16; b++) begin
                        @(negedge clk);
                        guard = 0;
                        while (!out_valid_b && guard < 2000) begin
                            @(negedge clk);
                            guard++;
                        end
                        check($sformatf("n16_f%0d_data[%0d]", f, b), out_data_b, dft_ref(f, b));
                        check($sformatf("n16_f%0d_last[%0d]", f, b), out_last_b, (b == 15));
                    end
                    @(negedge clk);
                    check("n16_b2b_ready", in_ready_b, 1);
                    check("n16_b2b_busy", busy_b, 0);
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
